msx_bus_arbiter: RTL and testbench
==================================

# msx_bus_arbiter

Two-master, one-target arbiter for the internal bus (`bus_*` handshake) that `msx_slot` produces. Master 0 is `msx_slot`. Master 1 is an internal requester, for example a configuration or initialisation sequencer. The arbiter grants the shared downstream target to one master per transaction using round-robin. It routes read data back to the owner of the pending read, and it completes reads that time out.

## Interface
Parameters:
- `RD_TIMEOUT`, default 255: number of clocks to wait for `s_rdata_en` after a read is accepted before forcing a response (1..255).

Ports:
- `clk` in 1: system clock.
- `reset_n` in 1: asynchronous active-low reset.
- `m0_memreq`, `m0_ioreq`, `m0_write` in 1 each: master 0 request type.
- `m0_address` in 16: master 0 address.
- `m0_wdata` in 8: master 0 write data.
- `m0_valid` in 1: master 0 request valid; held high until `m0_ready`.
- `m0_ready` out 1: master 0 request accepted.
- `m0_rdata` out 8: master 0 read data.
- `m0_rdata_en` out 1: one-clock pulse qualifying `m0_rdata`.
- `m1_*`: same set as `m0_*`, for master 1.
- `s_memreq`, `s_ioreq`, `s_write` out 1 each: downstream request type.
- `s_address` out 16: downstream address.
- `s_wdata` out 8: downstream write data.
- `s_valid` out 1: downstream request valid.
- `s_ready` in 1: target accepts the request.
- `s_rdata` in 8: target read data.
- `s_rdata_en` in 1: target read-data strobe.

## Operation
- States:
  - IDLE
  - GRANT0
  - GRANT1
  - WAIT_RD0
  - WAIT_RD1
- IDLE:
  - If exactly one `mX_valid` is high, go to GRANTX.
  - If both are high, grant the master that is not `last_grant`.
  - `last_grant` resets to 1, so master 0 wins the first tie.
  - `last_grant` updates on entry to GRANTX.
- GRANTX:
  - `s_*` request fields and `s_valid` follow master X combinationally.
  - `mX_ready = s_ready`. The other master's ready is 0.
  - When `s_valid & s_ready` and `s_write=1`: go to IDLE.
  - When `s_valid & s_ready` and `s_write=0`: go to WAIT_RDX and load the timeout counter with `RD_TIMEOUT`.
  - If `mX_valid` drops before acceptance (protocol violation): go to IDLE with no transfer.
- WAIT_RDX:
  - `s_valid = 0`. Both readies are 0.
  - On `s_rdata_en`: register `mX_rdata = s_rdata` and pulse `mX_rdata_en` for one clock, then go to IDLE.
  - Otherwise decrement the counter. When it reaches 0, register `mX_rdata = 8'hFF`, pulse `mX_rdata_en`, then go to IDLE.
  - An `s_rdata_en` arriving in IDLE or GRANTx (late or unsolicited) is ignored.
- `s_*` request fields are 0 when the state is not GRANTx.
- Non-owner `rdata_en` is always 0.
- `mX_rdata` holds its last value between pulses.

## Timing
- Reset values:
  - state IDLE, `last_grant = 1`, counter 0.
  - `s_valid`, `s_memreq`, `s_ioreq`, `s_write` = 0; `s_address = 16'h0000`; `s_wdata = 8'h00`.
  - `m0_ready`, `m1_ready`, `m0_rdata_en`, `m1_rdata_en` = 0; `m0_rdata`, `m1_rdata` = 8'h00.
- Grant latency:
  - `mX_valid` rising at edge N means `s_valid` is high during cycle N+1.
  - Back-to-back requests need at least one IDLE cycle between them.
- Ready path: `s_ready` to `mX_ready` is combinational, with zero latency.
- Read return: `s_rdata_en` at edge K gives `mX_rdata_en` high for the cycle after edge K, i.e. one clock of latency.
- Timeout: the response pulse occurs `RD_TIMEOUT+1` clocks after acceptance if no `s_rdata_en` arrives.
- Simultaneous `s_rdata_en` and counter reaching 0: the real data wins.
- Reset asserted mid-transaction:
  - All outputs return to reset values immediately (asynchronously).
  - The pending read is dropped and no `rdata_en` pulse is generated.

## Test plan
- Write, master 0 only:
  - Stimulus: `m0` io write to `16'h0098`, data `8'h12`; `s_ready` asserted 3 clocks after `s_valid`.
  - Required: `s_address = 16'h0098`, `s_wdata = 8'h12`, `s_ioreq = 1`, `s_write = 1`.
  - Required: `m0_ready` pulses 1 clock; `m1_ready` stays 0; return to IDLE.
- Read, master 1:
  - Stimulus: `m1` mem read at `16'h4000`; target returns `8'hA5` 5 clocks after accept.
  - Required: `m1_rdata = 8'hA5` with a 1-clock `m1_rdata_en`.
  - Required: `m0_rdata_en` stays 0.
- Tie and round-robin:
  - Stimulus: after reset, `m0` and `m1` assert valid on the same edge, repeated 3 times.
  - Required: grant order is m0, m1, m0, m1, m0, m1.
  - Required: exactly one IDLE cycle between transfers.
- Read timeout:
  - Stimulus: `RD_TIMEOUT = 4`; `m0` read; target never strobes.
  - Required: `m0_rdata = 8'hFF`, `m0_rdata_en` pulses 5 clocks after accept.
  - Required: a later `s_rdata_en` is ignored.
- Reset during WAIT_RD1:
  - Stimulus: deassert `reset_n` asynchronously.
  - Required: all outputs go to 0 immediately.
  - Required: after release, an `m0` write completes normally with m0 granted first.
- Valid withdrawn in GRANT0:
  - Stimulus: `m0_valid` drops before `s_ready`.
  - Required: `s_valid` falls in the same cycle, state returns to IDLE, no `m0_ready`.

Source files
------------

// File: rtl/msx_bus_arbiter.sv
// msx_bus_arbiter: two-master, one-target round-robin arbiter for the msx_slot
// internal bus. It owns the downstream target for one transaction at a time,
// routes read data back to the owner of the pending read, and completes reads
// that never return data with 8'hFF once a timeout expires.
module msx_bus_arbiter #(
    parameter int unsigned RD_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset_n,

    input  logic        m0_memreq,
    input  logic        m0_ioreq,
    input  logic        m0_write,
    input  logic [15:0] m0_address,
    input  logic [7:0]  m0_wdata,
    input  logic        m0_valid,
    output logic        m0_ready,
    output logic [7:0]  m0_rdata,
    output logic        m0_rdata_en,

    input  logic        m1_memreq,
    input  logic        m1_ioreq,
    input  logic        m1_write,
    input  logic [15:0] m1_address,
    input  logic [7:0]  m1_wdata,
    input  logic        m1_valid,
    output logic        m1_ready,
    output logic [7:0]  m1_rdata,
    output logic        m1_rdata_en,

    output logic        s_memreq,
    output logic        s_ioreq,
    output logic        s_write,
    output logic [15:0] s_address,
    output logic [7:0]  s_wdata,
    output logic        s_valid,
    input  logic        s_ready,
    input  logic [7:0]  s_rdata,
    input  logic        s_rdata_en
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_GRANT0,
        S_GRANT1,
        S_WAIT_RD0,
        S_WAIT_RD1
    } state_e;

    localparam logic [7:0] TIMEOUT_LOAD = 8'(RD_TIMEOUT);

    state_e     state_q, state_d;
    logic       last_grant_q, last_grant_d;
    logic [7:0] rd_cnt_q, rd_cnt_d;
    logic [7:0] m0_rdata_q, m0_rdata_d;
    logic [7:0] m1_rdata_q, m1_rdata_d;
    logic       m0_rdata_en_q, m0_rdata_en_d;
    logic       m1_rdata_en_q, m1_rdata_en_d;

    // A pending read completes on real data, or when the counter is about to
    // reach zero; real data wins if both happen in the same clock.
    logic       rd_fire;
    logic [7:0] rd_value;
    assign rd_fire  = s_rdata_en || (rd_cnt_q <= 8'd1);
    assign rd_value = s_rdata_en ? s_rdata : 8'hFF;

    // Next-state logic: arbitration, acceptance, read completion and timeout.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // through the case statement can infer a latch.
        state_d       = state_q;
        last_grant_d  = last_grant_q;
        rd_cnt_d      = rd_cnt_q;
        m0_rdata_d    = m0_rdata_q;
        m1_rdata_d    = m1_rdata_q;
        m0_rdata_en_d = 1'b0;
        m1_rdata_en_d = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                // On a tie, master 0 wins only if master 1 was granted last.
                if (m0_valid && (!m1_valid || last_grant_q)) begin
                    state_d      = S_GRANT0;
                    last_grant_d = 1'b0;
                end else if (m1_valid) begin
                    state_d      = S_GRANT1;
                    last_grant_d = 1'b1;
                end
            end

            S_GRANT0: begin
                if (!m0_valid) begin
                    state_d = S_IDLE;
                end else if (s_ready) begin
                    if (m0_write) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d  = S_WAIT_RD0;
                        rd_cnt_d = TIMEOUT_LOAD;
                    end
                end
            end

            S_GRANT1: begin
                if (!m1_valid) begin
                    state_d = S_IDLE;
                end else if (s_ready) begin
                    if (m1_write) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d  = S_WAIT_RD1;
                        rd_cnt_d = TIMEOUT_LOAD;
                    end
                end
            end

            S_WAIT_RD0: begin
                if (rd_fire) begin
                    m0_rdata_d    = rd_value;
                    m0_rdata_en_d = 1'b1;
                    rd_cnt_d      = 8'd0;
                    state_d       = S_IDLE;
                end else begin
                    rd_cnt_d = rd_cnt_q - 8'd1;
                end
            end

            S_WAIT_RD1: begin
                if (rd_fire) begin
                    m1_rdata_d    = rd_value;
                    m1_rdata_en_d = 1'b1;
                    rd_cnt_d      = 8'd0;
                    state_d       = S_IDLE;
                end else begin
                    rd_cnt_d = rd_cnt_q - 8'd1;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    // Downstream request mux and ready routing; everything is 0 outside GRANTx.
    always_comb begin
        s_valid   = 1'b0;
        s_memreq  = 1'b0;
        s_ioreq   = 1'b0;
        s_write   = 1'b0;
        s_address = 16'h0000;
        s_wdata   = 8'h00;
        m0_ready  = 1'b0;
        m1_ready  = 1'b0;

        case (state_q)
            S_GRANT0: begin
                s_valid   = m0_valid;
                s_memreq  = m0_memreq;
                s_ioreq   = m0_ioreq;
                s_write   = m0_write;
                s_address = m0_address;
                s_wdata   = m0_wdata;
                m0_ready  = s_ready;
            end
            S_GRANT1: begin
                s_valid   = m1_valid;
                s_memreq  = m1_memreq;
                s_ioreq   = m1_ioreq;
                s_write   = m1_write;
                s_address = m1_address;
                s_wdata   = m1_wdata;
                m1_ready  = s_ready;
            end
            default: ;
        endcase
    end

    // State, arbitration history, timeout counter and read-response registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= S_IDLE;
            last_grant_q  <= 1'b1;
            rd_cnt_q      <= 8'd0;
            m0_rdata_q    <= 8'h00;
            m1_rdata_q    <= 8'h00;
            m0_rdata_en_q <= 1'b0;
            m1_rdata_en_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments, so every register samples the
            // values from before this edge regardless of statement order.
            state_q       <= state_d;
            last_grant_q  <= last_grant_d;
            rd_cnt_q      <= rd_cnt_d;
            m0_rdata_q    <= m0_rdata_d;
            m1_rdata_q    <= m1_rdata_d;
            m0_rdata_en_q <= m0_rdata_en_d;
            m1_rdata_en_q <= m1_rdata_en_d;
        end
    end

    assign m0_rdata    = m0_rdata_q;
    assign m1_rdata    = m1_rdata_q;
    assign m0_rdata_en = m0_rdata_en_q;
    assign m1_rdata_en = m1_rdata_en_q;

endmodule

// File: tb/tb_msx_bus_arbiter.sv
// Testbench for msx_bus_arbiter: directed stimulus, scoreboard queues of
// expected downstream transfers and read responses, popped by monitors.
// A second instance with RD_TIMEOUT = 4 shares all inputs for the timeout case.
`timescale 1ns/1ps
module tb_msx_bus_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n;
    logic        m0_memreq, m0_ioreq, m0_write, m0_valid;
    logic [15:0] m0_address;
    logic [7:0]  m0_wdata;
    logic        m1_memreq, m1_ioreq, m1_write, m1_valid;
    logic [15:0] m1_address;
    logic [7:0]  m1_wdata;
    logic        s_ready, s_rdata_en;
    logic [7:0]  s_rdata;

    logic        m0_ready, m0_rdata_en, m1_ready, m1_rdata_en;
    logic [7:0]  m0_rdata, m1_rdata;
    logic        s_memreq, s_ioreq, s_write, s_valid;
    logic [15:0] s_address;
    logic [7:0]  s_wdata;

    logic        t_m0_ready, t_m0_rdata_en, t_m1_ready, t_m1_rdata_en;
    logic [7:0]  t_m0_rdata, t_m1_rdata;
    logic        t_s_memreq, t_s_ioreq, t_s_write, t_s_valid;
    logic [15:0] t_s_address;
    logic [7:0]  t_s_wdata;

    msx_bus_arbiter dut (
        .clk(clk), .reset_n(reset_n),
        .m0_memreq(m0_memreq), .m0_ioreq(m0_ioreq), .m0_write(m0_write),
        .m0_address(m0_address), .m0_wdata(m0_wdata), .m0_valid(m0_valid),
        .m0_ready(m0_ready), .m0_rdata(m0_rdata), .m0_rdata_en(m0_rdata_en),
        .m1_memreq(m1_memreq), .m1_ioreq(m1_ioreq), .m1_write(m1_write),
        .m1_address(m1_address), .m1_wdata(m1_wdata), .m1_valid(m1_valid),
        .m1_ready(m1_ready), .m1_rdata(m1_rdata), .m1_rdata_en(m1_rdata_en),
        .s_memreq(s_memreq), .s_ioreq(s_ioreq), .s_write(s_write),
        .s_address(s_address), .s_wdata(s_wdata), .s_valid(s_valid),
        .s_ready(s_ready), .s_rdata(s_rdata), .s_rdata_en(s_rdata_en)
    );

    msx_bus_arbiter #(.RD_TIMEOUT(4)) dut_t (
        .clk(clk), .reset_n(reset_n),
        .m0_memreq(m0_memreq), .m0_ioreq(m0_ioreq), .m0_write(m0_write),
        .m0_address(m0_address), .m0_wdata(m0_wdata), .m0_valid(m0_valid),
        .m0_ready(t_m0_ready), .m0_rdata(t_m0_rdata), .m0_rdata_en(t_m0_rdata_en),
        .m1_memreq(m1_memreq), .m1_ioreq(m1_ioreq), .m1_write(m1_write),
        .m1_address(m1_address), .m1_wdata(m1_wdata), .m1_valid(m1_valid),
        .m1_ready(t_m1_ready), .m1_rdata(t_m1_rdata), .m1_rdata_en(t_m1_rdata_en),
        .s_memreq(t_s_memreq), .s_ioreq(t_s_ioreq), .s_write(t_s_write),
        .s_address(t_s_address), .s_wdata(t_s_wdata), .s_valid(t_s_valid),
        .s_ready(s_ready), .s_rdata(s_rdata), .s_rdata_en(s_rdata_en)
    );

    typedef struct {
        int          id;
        logic        mem;
        logic        io;
        logic        wr;
        logic [15:0] addr;
        logic [7:0]  data;
    } xfer_t;

    typedef struct {
        int         id;
        logic [7:0] data;
    } rd_t;

    xfer_t exp_x[$];
    rd_t   exp_rd[$];
    int    acc_cyc[$];
    int    cyc = 0;
    int    n_pass = 0;
    int    n_total = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int m, input logic v, input logic mem, input logic io,
                           input logic wr, input logic [15:0] a, input logic [7:0] d);
        if (m == 0) begin
            m0_valid = v; m0_memreq = mem; m0_ioreq = io; m0_write = wr;
            m0_address = a; m0_wdata = d;
        end else begin
            m1_valid = v; m1_memreq = mem; m1_ioreq = io; m1_write = wr;
            m1_address = a; m1_wdata = d;
        end
    endtask

    task automatic push_x(input int id, input logic mem, input logic io, input logic wr,
                          input logic [15:0] a, input logic [7:0] d);
        xfer_t e;
        e.id = id; e.mem = mem; e.io = io; e.wr = wr; e.addr = a; e.data = d;
        exp_x.push_back(e);
    endtask

    task automatic push_rd(input int id, input logic [7:0] d);
        rd_t r;
        r.id = id; r.data = d;
        exp_rd.push_back(r);
    endtask

    // Wait (bounded) for master m's ready, then step past the accepting edge.
    task automatic wait_ready(input int m, input int budget);
        logic got;
        got = 1'b0;
        for (int i = 0; i < budget && !got; i++) begin
            @(negedge clk);
            got = (m == 0) ? m0_ready : m1_ready;
        end
        check($sformatf("ready_m%0d_seen", m), got, 1);
        tick();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_s_ctl"}, {s_valid, s_memreq, s_ioreq, s_write}, 0);
        check({tag, "_s_address"}, s_address, 0);
        check({tag, "_s_wdata"}, s_wdata, 0);
        check({tag, "_ready_en"}, {m0_ready, m1_ready, m0_rdata_en, m1_rdata_en}, 0);
        check({tag, "_m0_rdata"}, m0_rdata, 0);
        check({tag, "_m1_rdata"}, m1_rdata, 0);
    endtask

    // Downstream transfer monitor: every accepted request must match the queue head.
    always @(negedge clk) begin : mon_xfer
        xfer_t e;
        if (reset_n && s_valid && s_ready) begin
            check("xfer_expected", exp_x.size() != 0, 1);
            if (exp_x.size() != 0) begin
                e = exp_x.pop_front();
                check("xfer_grant", m1_ready ? 1 : 0, e.id);
                check("xfer_ready_onehot", m0_ready ^ m1_ready, 1);
                check("xfer_type", {s_memreq, s_ioreq, s_write}, {e.mem, e.io, e.wr});
                check("xfer_address", s_address, e.addr);
                check("xfer_wdata", s_wdata, e.data);
                acc_cyc.push_back(cyc);
            end
        end
    end

    // Read-response monitor: every rdata_en pulse must match the queue head.
    always @(negedge clk) begin : mon_rd
        rd_t r;
        if (reset_n && (m0_rdata_en || m1_rdata_en)) begin
            check("rd_expected", exp_rd.size() != 0, 1);
            if (exp_rd.size() != 0) begin
                r = exp_rd.pop_front();
                check("rd_owner", m1_rdata_en ? 1 : 0, r.id);
                check("rd_single", m0_rdata_en & m1_rdata_en, 0);
                check("rd_data", (r.id == 1) ? m1_rdata : m0_rdata, r.data);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b1;
        set_req(0, 0, 0, 0, 0, 16'h0000, 8'h00);
        set_req(1, 0, 0, 0, 0, 16'h0000, 8'h00);
        s_ready = 1'b0; s_rdata_en = 1'b0; s_rdata = 8'h00;
        #1 reset_n = 1'b0;
        #1 check_reset_outputs("reset");
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;

        // Tie after reset, three rounds: m0, m1, m0, m1, m0, m1, one IDLE between.
        push_x(0, 1, 0, 1, 16'h1000, 8'h10);
        push_x(1, 1, 0, 1, 16'h2000, 8'h20);
        push_x(0, 1, 0, 1, 16'h1001, 8'h11);
        push_x(1, 1, 0, 1, 16'h2001, 8'h21);
        push_x(0, 1, 0, 1, 16'h1002, 8'h12);
        push_x(1, 1, 0, 1, 16'h2002, 8'h22);
        acc_cyc.delete();
        s_ready = 1'b1;
        fork
            begin
                for (int i = 0; i < 3; i++) begin
                    set_req(0, 1, 1, 0, 1, 16'(16'h1000 + i), 8'(8'h10 + i));
                    wait_ready(0, 20);
                end
                m0_valid = 1'b0;
            end
            begin
                for (int j = 0; j < 3; j++) begin
                    set_req(1, 1, 1, 0, 1, 16'(16'h2000 + j), 8'(8'h20 + j));
                    wait_ready(1, 20);
                end
                m1_valid = 1'b0;
            end
        join
        s_ready = 1'b0;
        check("rr_count", acc_cyc.size(), 6);
        for (int i = 1; i < acc_cyc.size(); i++)
            check("rr_gap", acc_cyc[i] - acc_cyc[i-1], 2);

        // Master 0 io write, s_ready three clocks after s_valid.
        tick();
        set_req(0, 1, 0, 1, 1, 16'h0098, 8'h12);
        push_x(0, 0, 1, 1, 16'h0098, 8'h12);
        @(negedge clk);
        check("wr_latency_pre", s_valid, 0);
        tick();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("wr_s_valid", s_valid, 1);
            check("wr_m0_ready_wait", m0_ready, 0);
            if (k == 0) begin
                check("wr_s_address", s_address, 16'h0098);
                check("wr_s_wdata", s_wdata, 8'h12);
                check("wr_s_type", {s_memreq, s_ioreq, s_write}, 3'b011);
            end
            tick();
        end
        s_ready = 1'b1;
        #1;
        check("wr_m0_ready", m0_ready, 1);
        check("wr_m1_ready", m1_ready, 0);
        tick();
        m0_valid = 1'b0; s_ready = 1'b0;
        @(negedge clk);
        check("wr_idle_s_valid", s_valid, 0);
        check("wr_idle_m0_ready", m0_ready, 0);
        check("wr_idle_s_address", s_address, 0);

        // Master 1 mem read, data returned 5 clocks after accept.
        tick();
        set_req(1, 1, 1, 0, 0, 16'h4000, 8'h00);
        push_x(1, 1, 0, 0, 16'h4000, 8'h00);
        s_ready = 1'b1;
        wait_ready(1, 10);
        m1_valid = 1'b0; s_ready = 1'b0;
        repeat (4) tick();
        s_rdata = 8'hA5; s_rdata_en = 1'b1;
        push_rd(1, 8'hA5);
        tick();
        s_rdata_en = 1'b0; s_rdata = 8'h00;
        @(negedge clk);
        check("rd_m1_en", m1_rdata_en, 1);
        check("rd_m1_data", m1_rdata, 8'hA5);
        check("rd_m0_en", m0_rdata_en, 0);
        @(negedge clk);
        check("rd_m1_en_pulse", m1_rdata_en, 0);
        check("rd_m1_data_hold", m1_rdata, 8'hA5);

        // Read timeout on the RD_TIMEOUT=4 instance; main instance gets the late data.
        tick();
        set_req(0, 1, 1, 0, 0, 16'h2345, 8'h00);
        push_x(0, 1, 0, 0, 16'h2345, 8'h00);
        s_ready = 1'b1;
        wait_ready(0, 10);
        m0_valid = 1'b0; s_ready = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            check($sformatf("to_en_clk%0d", k), t_m0_rdata_en, (k == 5));
            if (k == 5) check("to_data", t_m0_rdata, 8'hFF);
        end
        tick();
        s_rdata = 8'h3C; s_rdata_en = 1'b1;
        push_rd(0, 8'h3C);
        tick();
        s_rdata_en = 1'b0; s_rdata = 8'h00;
        @(negedge clk);
        check("to_late_en", {t_m0_rdata_en, t_m1_rdata_en}, 0);
        check("to_late_data", t_m0_rdata, 8'hFF);
        check("to_main_data", m0_rdata, 8'h3C);

        // Reset asserted asynchronously while master 1's read is pending.
        tick();
        set_req(1, 1, 1, 0, 0, 16'h5555, 8'h00);
        push_x(1, 1, 0, 0, 16'h5555, 8'h00);
        s_ready = 1'b1;
        wait_ready(1, 10);
        m1_valid = 1'b0; s_ready = 1'b0;
        tick();
        #2 reset_n = 1'b0;
        #1 check_reset_outputs("midreset");
        #3 reset_n = 1'b1;
        tick();
        s_rdata = 8'h77; s_rdata_en = 1'b1;
        tick();
        s_rdata_en = 1'b0; s_rdata = 8'h00;
        @(negedge clk);
        check("midreset_no_pulse", {m0_rdata_en, m1_rdata_en}, 0);
        tick();
        push_x(0, 1, 0, 1, 16'h0A0A, 8'hAA);
        push_x(1, 1, 0, 1, 16'h0B0B, 8'hBB);
        acc_cyc.delete();
        s_ready = 1'b1;
        fork
            begin
                set_req(0, 1, 1, 0, 1, 16'h0A0A, 8'hAA);
                wait_ready(0, 20);
                m0_valid = 1'b0;
            end
            begin
                set_req(1, 1, 1, 0, 1, 16'h0B0B, 8'hBB);
                wait_ready(1, 20);
                m1_valid = 1'b0;
            end
        join
        s_ready = 1'b0;
        check("midreset_xfers", acc_cyc.size(), 2);

        // Master 0 withdraws valid while granted and before s_ready.
        tick();
        set_req(0, 1, 1, 0, 1, 16'h0C0C, 8'hCC);
        tick();
        @(negedge clk);
        check("wd_s_valid_granted", s_valid, 1);
        check("wd_s_address", s_address, 16'h0C0C);
        m0_valid = 1'b0;
        #1;
        check("wd_s_valid_same_cycle", s_valid, 0);
        check("wd_m0_ready", m0_ready, 0);
        tick();
        s_ready = 1'b1;
        @(negedge clk);
        check("wd_idle_s_valid", s_valid, 0);
        check("wd_idle_s_address", s_address, 0);
        check("wd_idle_m0_ready", m0_ready, 0);
        tick();
        s_ready = 1'b0;
        set_req(1, 1, 0, 1, 1, 16'h0D0D, 8'hDD);
        push_x(1, 0, 1, 1, 16'h0D0D, 8'hDD);
        s_ready = 1'b1;
        wait_ready(1, 10);
        m1_valid = 1'b0; s_ready = 1'b0;

        repeat (3) @(negedge clk);
        check("xfer_queue_empty", exp_x.size(), 0);
        check("rd_queue_empty", exp_rd.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
